mem_access_unit: RTL

Parametrised load/store unit placed between the pipeline's memory stage and the data-memory bus. Per request it checks alignment, generates byte enables and lane-replicated write data, and runs a request/grant/response handshake with memory that has a timeout. For loads it extracts the addressed byte, halfword, word or doubleword lane and sign- or zero-extends it. One access is outstanding at a time, and the result is returned on a valid/ready response port.

---
 rtl/mem_access_pkg.sv | 23 ++
 rtl/mem_access_unit_load_ext.sv | 22 ++
 rtl/mem_access_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM states and lane helpers for the load/store unit
package mem_access_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // Size mask shifted up to the addressed byte; callers keep the low DATA_W/8 bits.
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] m;
    m = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
    return m << offset;
  endfunction

  // Low 2^size bytes copied across a 64-bit bus; callers keep the low DATA_W bits.
  function automatic logic [63:0] replicate(input logic [1:0] size, input logic [63:0] data);
    return size == SZ_B ? {8{data[7:0]}} :
           size == SZ_H ? {4{data[15:0]}} :
           size == SZ_W ? {2{data[31:0]}} : data;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_ext.sv
// load_ext: selects the addressed load lane and sign/zero-extends it to DATA_W
module load_ext
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]             data,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic [1:0]                    size,
  input  logic                          zext,
  output logic [DATA_W-1:0]             result
);
  logic [DATA_W-1:0] sh;
  logic              sg;

  assign sh = data >> {offset, 3'b000};
  assign sg = ~zext;
  // Extension is built at 64 bits so one expression serves both bus widths.
  assign result = DATA_W'(size == SZ_B ? {{56{sg & sh[7]}}, sh[7:0]} :
                          size == SZ_H ? {{48{sg & sh[15]}}, sh[15:0]} :
                          size == SZ_W ? {{32{sg & sh[31]}}, sh[31:0]} : 64'(sh));
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store unit with alignment check and bus timeout
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic [TAG_W-1:0]    resp_tag,
  output logic                resp_exc,
  output logic                resp_err,
  output logic                busy
);
  localparam int BW = DATA_W / 8;
  localparam int OB = $clog2(BW);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

  state_t            state, nxt;
  logic              st, un;
  logic [1:0]        sz;
  logic [OB-1:0]     off;
  logic [CW-1:0]     cnt;
  logic              mis, in_bus, done, expired;
  logic [DATA_W-1:0] ext;

  assign mis = (req_size == SZ_H && req_addr[0]) ||
               (req_size == SZ_W && req_addr[1:0] != 2'b00) ||
               (req_size == SZ_D && (DATA_W == 32 || req_addr[2:0] != 3'b000));
  assign in_bus  = state == REQ || state == WAIT;
  assign done    = (state == REQ && mem_gnt && mem_rvalid) || (state == WAIT && mem_rvalid);
  // A response arriving in the final allowed cycle beats the timeout.
  assign expired = TIMEOUT != 0 && in_bus && cnt == CW'(TIMEOUT - 1) && !done;

  assign req_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign resp_valid = state == RESP;
  assign mem_req    = state == REQ;
  assign mem_we     = state == REQ && st;

  load_ext #(.DATA_W(DATA_W)) u_ext (
    .data   (mem_rdata),
    .offset (off),
    .size   (sz),
    .zext   (un),
    .result (ext)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= nxt;
  end

  // Next-state logic; gnt/rvalid only matter while a bus cycle is open.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? (mis ? RESP : REQ) : IDLE;
      REQ:     nxt = done || expired ? RESP : mem_gnt ? WAIT : REQ;
      WAIT:    nxt = done || expired ? RESP : WAIT;
      RESP:    nxt = resp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end

  // Request capture, bus drive registers, timeout counter and response result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= 1'b0;
      sz        <= SZ_B;
      un        <= 1'b0;
      off       <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      resp_data <= '0;
      resp_tag  <= '0;
      resp_exc  <= 1'b0;
      resp_err  <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      st        <= req_store;
      sz        <= req_size;
      un        <= req_unsigned;
      off       <= req_addr[OB-1:0];
      cnt       <= '0;
      mem_addr  <= {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
      mem_be    <= BW'(be_mask(req_size, 3'(req_addr[OB-1:0])));
      mem_wdata <= DATA_W'(replicate(req_size, 64'(req_wdata)));
      resp_data <= '0;
      resp_tag  <= req_tag;
      resp_exc  <= mis;
      resp_err  <= 1'b0;
    end else if (in_bus) begin
      cnt      <= cnt + 1'b1;
      resp_err <= expired;
      if (done && !st) resp_data <= ext;
    end
  end
endmodule
